// File: rtl/accumulator_unit.sv
`default_nettype none
// ============================================================================
//  Module      : accumulator_unit
//  Description : Single W-bit accumulator for an accumulator-style datapath.
//                Loads from the register-file operand, the ALU result, or a
//                4-bit immediate nibble merged into the low or high half of
//                the low byte. DataOut is a pure register output.
//  Revision    : 1.0 - initial release
// ============================================================================
module accumulator_unit #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         Write_En,
    input  logic         From_Reg,
    input  logic         From_Imm,
    input  logic         From_ALU,
    input  logic         Load_Hi,
    input  logic [W-1:0] RegInput,
    input  logic [W-1:0] ALUInput,
    input  logic [3:0]   Imm_in,
    output logic [W-1:0] DataOut
);

    // Stored accumulator value and its next-state
    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;

    // Current value with the immediate nibble merged into the chosen half
    logic [W-1:0] w_imm_merged;

    // Merge the immediate nibble into the stored value; all other bits keep
    // their current contents so two nibble writes can build a full byte.
    always_comb begin
        w_imm_merged = acc_q;
        if (Load_Hi) begin
            w_imm_merged[7:4] = Imm_in;
        end else begin
            w_imm_merged[3:0] = Imm_in;
        end
    end

    // Select the next value: From_Reg beats From_ALU beats From_Imm; only the
    // selected source is ever routed, so an unselected input cannot leak in.
    always_comb begin
        acc_d = acc_q;
        if (Write_En) begin
            if (From_Reg) begin
                acc_d = RegInput;
            end else if (From_ALU) begin
                acc_d = ALUInput;
            end else if (From_Imm) begin
                acc_d = w_imm_merged;
            end
        end
    end

    // Accumulator register; reset overrides any pending write
    always_ff @(posedge clk) begin
        if (Reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign DataOut = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_accumulator_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_accumulator_unit
//  Description : Self-checking bench for accumulator_unit (W = 8). A
//                behavioural model tracks the expected accumulator value and
//                is compared against DataOut every cycle; literal checks pin
//                the model at the key points of each directed sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_accumulator_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         Reset;
    logic         Write_En;
    logic         From_Reg;
    logic         From_Imm;
    logic         From_ALU;
    logic         Load_Hi;
    logic [W-1:0] RegInput;
    logic [W-1:0] ALUInput;
    logic [3:0]   Imm_in;
    logic [W-1:0] DataOut;

    int n_vec  = 0;
    int n_miss = 0;

    logic [W-1:0] model_acc = '0;
    bit           chk_en    = 1'b0;

    always #5 clk = ~clk;

    accumulator_unit #(.W(W)) dut (
        .clk      (clk),
        .Reset    (Reset),
        .Write_En (Write_En),
        .From_Reg (From_Reg),
        .From_Imm (From_Imm),
        .From_ALU (From_ALU),
        .Load_Hi  (Load_Hi),
        .RegInput (RegInput),
        .ALUInput (ALUInput),
        .Imm_in   (Imm_in),
        .DataOut  (DataOut)
    );

    // Expected accumulator after one edge, written from the behavioural rules
    function automatic logic [W-1:0] spec_next(
        input logic [W-1:0] acc,
        input logic rst, input logic we,
        input logic fr, input logic fa, input logic fi, input logic lh,
        input logic [W-1:0] rv, input logic [W-1:0] av, input logic [3:0] iv
    );
        if (rst)      return '0;
        if (!we)      return acc;
        if (fr)       return rv;
        if (fa)       return av;
        if (fi && lh) return (acc & ~(W'(8'hF0))) | (W'(iv) << 4);
        if (fi)       return (acc & ~(W'(8'h0F))) | W'(iv);
        return acc;
    endfunction

    // Model advances on every rising edge from the inputs applied that cycle
    always @(posedge clk) begin
        model_acc <= spec_next(model_acc, Reset, Write_En, From_Reg, From_ALU,
                               From_Imm, Load_Hi, RegInput, ALUInput, Imm_in);
    end

    // Per-cycle comparison against the model, on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            n_vec = n_vec + 1;
            if (DataOut !== model_acc) begin
                n_miss = n_miss + 1;
                $display("FAIL cycle_compare t=%0t DataOut=%h model=%h", $time, DataOut, model_acc);
            end
        end
    end

    // Drive one cycle's inputs, then advance just past the next rising edge
    task automatic step(
        input logic rst, input logic we,
        input logic fr, input logic fa, input logic fi, input logic lh,
        input logic [W-1:0] rv, input logic [W-1:0] av, input logic [3:0] iv
    );
        Reset = rst; Write_En = we;
        From_Reg = fr; From_ALU = fa; From_Imm = fi; Load_Hi = lh;
        RegInput = rv; ALUInput = av; Imm_in = iv;
        @(posedge clk);
        #1;
    endtask

    // Hand-computed literal expectation: checks both the DUT and the model
    task automatic lit(input string name, input logic [W-1:0] exp);
        n_vec = n_vec + 1;
        if (DataOut !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s DataOut=%h expected=%h", name, DataOut, exp);
        end
        n_vec = n_vec + 1;
        if (model_acc !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s_model model=%h expected=%h", name, model_acc, exp);
        end
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] held;
        Reset = 1'b1; Write_En = 1'b0; From_Reg = 1'b0; From_ALU = 1'b0;
        From_Imm = 1'b0; Load_Hi = 1'b0; RegInput = '0; ALUInput = '0; Imm_in = '0;
        @(posedge clk); #1;

        // Reset beats a pending register load
        step(1, 1, 1, 0, 0, 0, 8'hFF, 8'h00, 4'h0);
        chk_en = 1'b1;
        lit("reset_over_write", 8'h00);
        step(0, 0, 0, 0, 0, 0, 8'hFF, 8'hFF, 4'hF);
        lit("reset_release_hold", 8'h00);

        // Register then ALU loads
        step(0, 1, 1, 0, 0, 0, 8'h5A, 8'h00, 4'h0);
        lit("load_reg", 8'h5A);
        step(0, 1, 0, 1, 0, 0, 8'h00, 8'hA5, 4'h0);
        lit("load_alu", 8'hA5);

        // Immediate nibbles: low then high
        step(0, 1, 0, 0, 1, 0, 8'h00, 8'h00, 4'hF);
        lit("imm_lo", 8'hAF);
        step(0, 1, 0, 0, 1, 1, 8'h00, 8'h00, 4'hC);
        lit("imm_hi", 8'hCF);

        // Hold with every select high and inputs toggling, including
        // mid-cycle changes that must never reach DataOut
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 1, 1, 1'(i), 8'($urandom), 8'($urandom), 4'($urandom));
            RegInput = 8'($urandom); ALUInput = 8'($urandom); Imm_in = 4'($urandom);
            Load_Hi = ~Load_Hi;
            #2;
            lit("hold", 8'hCF);
        end

        // Priority among simultaneous selects
        step(0, 1, 1, 1, 1, 0, 8'h11, 8'h22, 4'h3);
        lit("prio_reg", 8'h11);
        step(0, 1, 0, 1, 1, 0, 8'h11, 8'h22, 4'h3);
        lit("prio_alu", 8'h22);
        step(0, 1, 0, 0, 1, 0, 8'h11, 8'h22, 4'h3);
        lit("prio_imm", 8'h23);

        // No select high is a no-op even with Write_En
        step(0, 1, 0, 0, 0, 1, 8'hEE, 8'hDD, 4'h9);
        lit("no_select", 8'h23);

        // Reset mid-operation, then rebuild from zero
        step(1, 1, 0, 1, 0, 0, 8'h00, 8'h99, 4'h0);
        lit("reset_mid", 8'h00);
        step(0, 1, 0, 0, 1, 0, 8'h00, 8'h00, 4'h7);
        lit("imm_after_reset", 8'h07);

        // High then low nibble builds a byte; Load_Hi ignored on reg path
        step(0, 1, 0, 0, 1, 1, 8'h00, 8'h00, 4'h4);
        lit("imm_hi_first", 8'h47);
        step(0, 1, 0, 0, 1, 0, 8'h00, 8'h00, 4'hB);
        lit("imm_lo_second", 8'h4B);
        step(0, 1, 1, 0, 0, 1, 8'h3C, 8'h00, 4'hF);
        lit("reg_ignores_loadhi", 8'h3C);

        // Random sequence checked by the per-cycle model compare
        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 8'($urandom), 8'($urandom), 4'($urandom));
        end

        // Final hold keeps the value across several cycles
        held = model_acc;
        step(0, 0, 1, 1, 1, 1, 8'h00, 8'h00, 4'h0);
        step(0, 0, 1, 1, 1, 0, 8'hFF, 8'hFF, 4'hF);
        n_vec = n_vec + 1;
        if (DataOut !== held) begin
            n_miss = n_miss + 1;
            $display("FAIL final_hold DataOut=%h expected=%h", DataOut, held);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
